// File: rtl/frame_to_axis_if.sv
// ---------------------------------------------------------------------------
// frame_to_axis_if
// AXI4-Stream video bus carried between frame_to_axis and its downstream sink.
//
// Signals:
//   m_tvalid  source -> sink  beat valid
//   m_tready  sink -> source  sink ready
//   m_tdata   source -> sink  pixel value (BPP bits)
//   m_tuser   source -> sink  start-of-frame, set on the first beat of a frame
//   m_tlast   source -> sink  end-of-line, set on the beat at column WIDTH-1
//
// Modports:
//   master  the stream source (frame_to_axis)
//   slave   the stream sink
// ---------------------------------------------------------------------------
interface frame_to_axis_if #(
    parameter int BPP = 8
);
    logic           m_tvalid;
    logic           m_tready;
    logic [BPP-1:0] m_tdata;
    logic           m_tuser;
    logic           m_tlast;

    modport master (
        output m_tvalid,
        output m_tdata,
        output m_tuser,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tvalid,
        input  m_tdata,
        input  m_tuser,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/frame_to_axis.sv
// ---------------------------------------------------------------------------
// frame_to_axis
// Converts camera-style timing (fval/lval/dval/pix_data) into an AXI4-Stream
// video stream. A small first-word-fall-through FIFO absorbs sink
// backpressure. Frame geometry is checked against WIDTH x HEIGHT, completed
// frames are counted, and overflow / geometry errors are kept as sticky flags.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   fval       frame valid
//   lval       line valid
//   dval       data valid
//   pix_data   pixel value (BPP bits)
//   clr        one-cycle pulse clearing overflow / line_err / frame_err
//   axis       AXI4-Stream master (m_tvalid/m_tready/m_tdata/m_tuser/m_tlast)
//   frame_cnt  completed frames, wraps 0xFFFF -> 0
//   overflow   sticky: a pixel was dropped because the FIFO was full
//   line_err   sticky: a line had a pixel count other than WIDTH
//   frame_err  sticky: a frame had a line count other than HEIGHT
// ---------------------------------------------------------------------------
module frame_to_axis #(
    parameter int BPP        = 8,
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fval,
    input  logic             lval,
    input  logic             dval,
    input  logic [BPP-1:0]   pix_data,
    input  logic             clr,
    frame_to_axis_if.master  axis,
    output logic [15:0]      frame_cnt,
    output logic             overflow,
    output logic             line_err,
    output logic             frame_err
);

    // Counters get one spare code above WIDTH / HEIGHT so a saturated value
    // can never alias the nominal geometry.
    localparam int CW    = $clog2(WIDTH + 2);
    localparam int RW    = $clog2(HEIGHT + 2);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int DW    = BPP + 2;

    localparam logic [CW-1:0]    WIDTH_C  = CW'(WIDTH);
    localparam logic [CW-1:0]    LAST_COL = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    COL_ONE  = CW'(1);
    localparam logic [CW-1:0]    COL_MAX  = {CW{1'b1}};
    localparam logic [RW-1:0]    HEIGHT_C = RW'(HEIGHT);
    localparam logic [RW-1:0]    ROW_ONE  = RW'(1);
    localparam logic [RW-1:0]    ROW_MAX  = {RW{1'b1}};
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic             fval_d_reg;
    logic             lval_d_reg;
    logic             sync_reg;
    logic             sof_reg;
    logic [CW-1:0]    col_reg;
    logic [RW-1:0]    row_reg;
    logic [15:0]      frame_cnt_reg;
    logic             overflow_reg;
    logic             line_err_reg;
    logic             frame_err_reg;

    // FIFO: RAM body plus one output register holding the head word.
    logic [DW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] ram_cnt_reg;
    logic             out_valid_reg;
    logic [DW-1:0]    out_data_reg;

    // -----------------------------------------------------------------------
    // Combinational next-state
    // -----------------------------------------------------------------------
    logic             fval_rise;
    logic             fval_fall;
    logic             lval_fall;
    logic             active;
    logic             accept;
    logic             in_range;
    logic [CW-1:0]    col_cur;
    logic [RW-1:0]    row_cur;
    logic             sof_cur;
    logic [RW-1:0]    row_chk;
    logic [CW-1:0]    col_next;
    logic [RW-1:0]    row_next;
    logic             sof_next;
    logic             wr_req;
    logic             wr_ok;
    logic             rd;
    logic [CNT_W-1:0] fifo_cnt;
    logic             bypass;
    logic             load_ram;
    logic             ram_wr;
    logic [DW-1:0]    wr_word;
    logic             ovf_evt;
    logic             line_evt;
    logic             frame_evt;

    function automatic logic [CW-1:0] col_inc(input logic [CW-1:0] v);
        return (v == COL_MAX) ? v : v + COL_ONE;
    endfunction

    function automatic logic [RW-1:0] row_inc(input logic [RW-1:0] v);
        return (v == ROW_MAX) ? v : v + ROW_ONE;
    endfunction

    always_comb begin
        fval_rise = fval & ~fval_d_reg;
        fval_fall = ~fval & fval_d_reg;
        lval_fall = ~lval & lval_d_reg;

        // The rising fval edge that sets sync also starts the frame, so a
        // pixel arriving in that very cycle is already treated as in-frame.
        active = sync_reg | fval_rise;
        accept = active & fval & lval & dval;

        // Values as seen after the frame-start clear.
        col_cur = fval_rise ? '0 : col_reg;
        row_cur = fval_rise ? '0 : row_reg;
        sof_cur = fval_rise | sof_reg;

        in_range = (col_cur < WIDTH_C);
        wr_req   = accept & in_range;
        wr_word  = {sof_cur, (col_cur == LAST_COL), pix_data};

        // FIFO occupancy includes the head held in the output register.
        rd       = out_valid_reg & axis.m_tready;
        fifo_cnt = ram_cnt_reg + (out_valid_reg ? CNT_ONE : '0);
        wr_ok    = wr_req & ((fifo_cnt < DEPTH_C) | rd);
        ovf_evt  = wr_req & ~wr_ok;

        // The head register refills from RAM when possible; with an empty RAM
        // a new write goes straight into it, giving one-cycle latency.
        load_ram = (~out_valid_reg | rd) & (ram_cnt_reg != '0);
        bypass   = (~out_valid_reg | rd) & (ram_cnt_reg == '0) & wr_ok;
        ram_wr   = wr_ok & ~bypass;

        // The line whose lval falls together with fval still counts.
        row_chk = lval_fall ? row_inc(row_cur) : row_cur;

        line_evt  = (accept & ~in_range) | (active & lval_fall & (col_cur != WIDTH_C));
        frame_evt = sync_reg & fval_fall & (row_chk != HEIGHT_C);

        col_next = col_reg;
        row_next = row_reg;
        sof_next = sof_reg;
        if (active) begin
            if (lval_fall) begin
                col_next = '0;
            end else if (accept) begin
                col_next = col_inc(col_cur);
            end else begin
                col_next = col_cur;
            end
            row_next = (lval_fall & fval) ? row_inc(row_cur) : row_cur;
            // sof is consumed only by a pixel that really entered the FIFO.
            sof_next = wr_ok ? 1'b0 : sof_cur;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // Edge registers start high so that releasing reset in the middle
            // of a frame is never mistaken for a new frame start.
            fval_d_reg    <= 1'b1;
            lval_d_reg    <= 1'b1;
            sync_reg      <= 1'b0;
            sof_reg       <= 1'b0;
            col_reg       <= '0;
            row_reg       <= '0;
            frame_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
            line_err_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ram_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            fval_d_reg <= fval;
            lval_d_reg <= lval;
            if (fval_rise) begin
                sync_reg <= 1'b1;
            end
            col_reg <= col_next;
            row_reg <= row_next;
            sof_reg <= sof_next;
            if (sync_reg & fval_fall) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end

            // An event in the same cycle as clr leaves the flag set.
            overflow_reg  <= (overflow_reg  & ~clr) | ovf_evt;
            line_err_reg  <= (line_err_reg  & ~clr) | line_evt;
            frame_err_reg <= (frame_err_reg & ~clr) | frame_evt;

            if (ram_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (load_ram) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({ram_wr, load_ram})
                2'b10:   ram_cnt_reg <= ram_cnt_reg + CNT_ONE;
                2'b01:   ram_cnt_reg <= ram_cnt_reg - CNT_ONE;
                default: ram_cnt_reg <= ram_cnt_reg;
            endcase
            out_valid_reg <= (out_valid_reg & ~rd) | load_ram | bypass;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage and registered read into the head register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[wr_ptr_reg] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (load_ram) begin
            out_data_reg <= mem[rd_ptr_reg];
        end else if (bypass) begin
            out_data_reg <= wr_word;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign axis.m_tvalid = out_valid_reg;
    assign axis.m_tuser  = out_data_reg[DW-1];
    assign axis.m_tlast  = out_data_reg[DW-2];
    assign axis.m_tdata  = out_data_reg[BPP-1:0];

    assign frame_cnt = frame_cnt_reg;
    assign overflow  = overflow_reg;
    assign line_err  = line_err_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_frame_to_axis.sv
// ---------------------------------------------------------------------------
// tb_frame_to_axis
// Scoreboard bench for frame_to_axis with WIDTH=4, HEIGHT=2, FIFO_DEPTH=8.
// Expected beats are queued as pixels are driven and compared as the stream
// delivers them; flags and frame count are compared after each scenario.
// ---------------------------------------------------------------------------
module tb_frame_to_axis;

    localparam int BPP   = 8;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 8;

    typedef struct {
        logic [BPP-1:0] data;
        logic           user;
        logic           last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           fval = 1'b0;
    logic           lval = 1'b0;
    logic           dval = 1'b0;
    logic [BPP-1:0] pix_data = '0;
    logic           clr = 1'b0;
    logic [15:0]    frame_cnt;
    logic           overflow;
    logic           line_err;
    logic           frame_err;

    frame_to_axis_if #(.BPP(BPP)) axis ();

    frame_to_axis #(
        .BPP        (BPP),
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fval      (fval),
        .lval      (lval),
        .dval      (dval),
        .pix_data  (pix_data),
        .clr       (clr),
        .axis      (axis),
        .frame_cnt (frame_cnt),
        .overflow  (overflow),
        .line_err  (line_err),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];
    beat_t mon_b;
    logic  exp_sof      = 1'b0;
    logic  expect_on    = 1'b1;
    logic  drop_all     = 1'b0;
    logic  toggle_ready = 1'b0;
    int    exp_frames   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Beat monitor: sampled on the falling edge, ahead of the handshake edge.
    always @(negedge clk) begin
        if (!rst && axis.m_tvalid && axis.m_tready) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_b = exp_q.pop_front();
                $display("beat data=%0d user=%0b last=%0b", axis.m_tdata, axis.m_tuser, axis.m_tlast);
                check("tdata", 32'(axis.m_tdata), 32'(mon_b.data));
                check("tuser", 32'(axis.m_tuser), 32'(mon_b.user));
                check("tlast", 32'(axis.m_tlast), 32'(mon_b.last));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_ready) axis.m_tready = ~axis.m_tready;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic frame_begin();
        fval = 1'b1;
        exp_sof = 1'b1;
        step();
        step();
    endtask

    task automatic frame_end();
        fval = 1'b0;
        if (expect_on) exp_frames++;
        step();
        step();
    endtask

    task automatic send_line(input int n, input int base);
        beat_t b;
        if (n == 0) begin
            lval = 1'b1;
            step();
        end
        for (int i = 0; i < n; i++) begin
            lval = 1'b1;
            dval = 1'b1;
            pix_data = BPP'(base + i);
            if (expect_on && !drop_all && i < W) begin
                b.data = BPP'(base + i);
                b.user = exp_sof;
                b.last = (i == W - 1);
                exp_q.push_back(b);
                exp_sof = 1'b0;
            end
            step();
        end
        lval = 1'b0;
        dval = 1'b0;
        pix_data = '0;
        step();
        step();
    endtask

    task automatic nominal_frame(input int base);
        frame_begin();
        send_line(W, base);
        send_line(W, base + W);
        frame_end();
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || axis.m_tvalid) && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(n < 300), 32'd1);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axis.m_tready = 1'b1;
        idle(3);
        rst = 1'b0;
        step();

        // Reset state
        check("rst_tvalid", 32'(axis.m_tvalid), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_line_err", 32'(line_err), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);

        // Nominal frame, sink always ready
        nominal_frame(1);
        wait_drain("drain_nominal");
        check("nom_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("nom_flags", {29'd0, overflow, line_err, frame_err}, 32'd0);

        // Overflow: frame A fills the FIFO, frame B's first line is dropped,
        // so tuser moves to the first pixel of B's second line.
        axis.m_tready = 1'b0;
        nominal_frame(11);
        check("stall_tvalid", 32'(axis.m_tvalid), 32'd1);
        check("stall_head_data", 32'(axis.m_tdata), 32'd11);
        check("stall_head_user", 32'(axis.m_tuser), 32'd1);
        check("stall_overflow", 32'(overflow), 32'd0);
        frame_begin();
        drop_all = 1'b1;
        send_line(W, 21);
        drop_all = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head_data", 32'(axis.m_tdata), 32'd11);
        axis.m_tready = 1'b1;
        wait_drain("drain_ovf_a");
        send_line(W, 25);
        frame_end();
        wait_drain("drain_ovf_b");
        check("ovf_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("ovf_frame_err", 32'(frame_err), 32'd0);
        check("ovf_line_err", 32'(line_err), 32'd0);
        pulse_clr();
        check("ovf_clr", 32'(overflow), 32'd0);

        // Short line: no tlast on it, line_err set
        frame_begin();
        send_line(3, 31);
        send_line(W, 34);
        frame_end();
        wait_drain("drain_short");
        check("short_line_err", 32'(line_err), 32'd1);
        check("short_frame_err", 32'(frame_err), 32'd0);
        pulse_clr();
        check("short_clr", 32'(line_err), 32'd0);
        nominal_frame(91);
        wait_drain("drain_after_clr");
        check("after_clr_line_err", 32'(line_err), 32'd0);

        // Long line: fifth pixel dropped, tlast on the fourth
        frame_begin();
        send_line(5, 41);
        send_line(W, 46);
        frame_end();
        wait_drain("drain_long");
        check("long_line_err", 32'(line_err), 32'd1);
        check("long_overflow", 32'(overflow), 32'd0);
        pulse_clr();

        // Zero-pixel line inside a frame: line_err, and three lines -> frame_err
        frame_begin();
        send_line(W, 51);
        send_line(0, 0);
        send_line(W, 55);
        frame_end();
        wait_drain("drain_zero");
        check("zero_line_err", 32'(line_err), 32'd1);
        check("zero_frame_err", 32'(frame_err), 32'd1);
        pulse_clr();
        check("zero_clr", {30'd0, line_err, frame_err}, 32'd0);

        // Single-line frame
        frame_begin();
        send_line(W, 101);
        frame_end();
        wait_drain("drain_one_line");
        check("one_line_frame_err", 32'(frame_err), 32'd1);
        check("one_line_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        pulse_clr();
        check("one_line_clr", 32'(frame_err), 32'd0);

        // Sink ready toggling every cycle
        toggle_ready = 1'b1;
        nominal_frame(111);
        toggle_ready = 1'b0;
        axis.m_tready = 1'b1;
        wait_drain("drain_toggle");
        check("toggle_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        // Reset in the middle of a frame
        axis.m_tready = 1'b0;
        expect_on = 1'b0;
        frame_begin();
        lval = 1'b1;
        dval = 1'b1;
        pix_data = 8'd61;
        step();
        pix_data = 8'd62;
        step();
        rst = 1'b1;
        exp_frames = 0;
        pix_data = 8'd63;
        step();
        pix_data = 8'd64;
        step();
        rst = 1'b0;
        lval = 1'b0;
        dval = 1'b0;
        step();
        axis.m_tready = 1'b1;
        send_line(W, 65);
        frame_end();
        check("midrst_tvalid", 32'(axis.m_tvalid), 32'd0);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        expect_on = 1'b1;
        nominal_frame(71);
        wait_drain("drain_midrst");
        check("midrst_next_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("midrst_flags", {29'd0, overflow, line_err, frame_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
